// File: rtl/frame_window_pkg.sv
// rtl/frame_window_pkg.sv - shared acoustic-path widths, default window length and FSM states
package frame_window_pkg;

   localparam int I_BW           = 8;
   localparam int N_COEF         = 13;
   localparam int P_BW           = I_BW * N_COEF;
   localparam int NUM_FRAMES_DEF = 50;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_STREAM = 2'd2
   } fw_state_e;

endpackage

// File: rtl/frame_window_mem.sv
// rtl/frame_window_mem.sv - 1R1W frame store, synchronous write, registered read with read enable
module frame_window_mem
   import frame_window_pkg::*;
#(
   parameter int W     = P_BW,
   parameter int DEPTH = NUM_FRAMES_DEF + 1,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds its value when rd_en is low, giving the stall hold for free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/frame_window.sv
// rtl/frame_window.sv - sliding window frame buffer; FRAME_WINDOW_OVF_EN enables sticky overflow_o
module frame_window #(
   parameter int P_BW       = frame_window_pkg::P_BW,
   parameter int NUM_FRAMES = frame_window_pkg::NUM_FRAMES_DEF,
   parameter int STRIDE     = 5
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            en_i,
   input  logic [P_BW-1:0] data_i,
   input  logic            valid_i,
   input  logic            last_i,
   output logic [P_BW-1:0] data_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            last_o,
   output logic            overflow_o
);
   import frame_window_pkg::*;

   localparam int DEPTH = NUM_FRAMES + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = $clog2(NUM_FRAMES + 1);
   localparam int SW    = $clog2(STRIDE + 1);

   fw_state_e       state;
   logic [AW-1:0]   wr_ptr, rd_ptr, rd_addr;
   logic [FW-1:0]   fill, word_cnt;
   logic [SW-1:0]   stride_cnt;
   logic            pending, spare_used, valid_q, last_q;
   logic            full, drop, accept, trig, take, start, rd_en;
   logic            unused_last;

   assign unused_last = last_i;

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   assign full   = (fill == FW'(NUM_FRAMES));
   assign drop   = en_i && valid_i && (state == ST_STREAM) && spare_used;
   assign accept = en_i && valid_i && !drop;
   assign trig   = accept && ((fill == FW'(NUM_FRAMES - 1)) ||
                              (full && stride_cnt == SW'(STRIDE - 1)));
   assign take   = valid_q && ready_i;
   assign start  = en_i && pending &&
                   ((state == ST_IDLE) || (state == ST_STREAM && take && last_q));
   assign rd_en  = start || (en_i && state == ST_STREAM && take && !last_q);
   // Oldest frame sits one past wr_ptr: wr_ptr - NUM_FRAMES mod (NUM_FRAMES+1)
   assign rd_addr = start ? next_addr(wr_ptr) : next_addr(rd_ptr);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_FILL;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         word_cnt   <= '0;
         stride_cnt <= '0;
         pending    <= 1'b0;
         spare_used <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else if (!en_i) begin
         state      <= ST_FILL;
         wr_ptr     <= '0;
         fill       <= '0;
         stride_cnt <= '0;
         pending    <= 1'b0;
         spare_used <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= next_addr(wr_ptr);
            if (!full)                              fill <= fill + 1'b1;
            else if (stride_cnt == SW'(STRIDE - 1)) stride_cnt <= '0;
            else                                    stride_cnt <= stride_cnt + 1'b1;
         end

         if (trig)       pending <= 1'b1;
         else if (start) pending <= 1'b0;

         // A frame landing on the window's entry edge already occupies the spare slot
         if (start)                             spare_used <= accept;
         else if (state == ST_STREAM && accept) spare_used <= 1'b1;

         case (state)
            ST_FILL:   if (trig) state <= ST_IDLE;
            ST_IDLE:   if (start) state <= ST_STREAM;
            ST_STREAM: if (take && last_q && !pending) state <= ST_IDLE;
            default:   state <= ST_FILL;
         endcase

         if (start) begin
            rd_ptr   <= rd_addr;
            word_cnt <= '0;
            valid_q  <= 1'b1;
            last_q   <= (NUM_FRAMES == 1);
         end else if (state == ST_STREAM && take) begin
            if (last_q) begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end else begin
               rd_ptr   <= rd_addr;
               word_cnt <= word_cnt + 1'b1;
               last_q   <= (word_cnt == FW'(NUM_FRAMES - 2));
            end
         end
      end
   end

   frame_window_mem #(
      .W     (P_BW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .wr_en   (accept),
      .wr_addr (wr_ptr),
      .wr_data (data_i),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (data_o)
   );

   assign valid_o = valid_q;
   assign last_o  = last_q;

`ifdef FRAME_WINDOW_OVF_EN
   logic ovf;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)  ovf <= 1'b0;
      else if (!en_i) ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
   end
   assign overflow_o = ovf;
`else
   assign overflow_o = 1'b0;
`endif

endmodule
